clint_trap_ctrl: RTL



---
 rtl/clint_trap_ctrl_pkg.sv | 25 ++
 rtl/clint_trap_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clint_trap_ctrl_pkg.sv
// rtl/clint_trap_ctrl_pkg.sv - CSR addresses, privilege encodings, mcause codes and mstatus bit indices
package clint_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [1:0] PRIVILEG_USER    = 2'b00;
  localparam logic [1:0] PRIVILEG_MACHINE = 2'b11;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_MTIMER = 32'h8000_0007;

  localparam int MSTATUS_MIE     = 3;
  localparam int MSTATUS_MPIE    = 7;
  localparam int MSTATUS_MPP_LO  = 11;
  localparam int MSTATUS_MPP_HI  = 12;

  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'd0, a};
  endfunction

endpackage

// File: rtl/clint_trap_ctrl.sv
// rtl/clint_trap_ctrl.sv - trap/mret sequencer driving the CSR clint write port and PC redirect
// Optional: CLINT_VECTORED_EN enables vectored interrupt targets when mtvec mode is 2'b01.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        inst_ecall_i,
  input  logic        inst_ebreak_i,
  input  logic        inst_mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        timer_irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        clint_wr_en_o,
  output logic [31:0] clint_wr_addr_o,
  output logic [31:0] clint_wr_data_o,
  output logic        wr_privilege_en_o,
  output logic [1:0]  wr_privilege_ctrl_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MSTATUS,
    W_MCAUSE,
    W_MSTATUS_MRET,
    ASSERT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        is_mret_q, is_mret_d;

  logic        irq_taken;
  logic        trap_taken;
  logic        event_taken;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;

  assign irq_taken   = timer_irq_i & csr_mstatus_i[MSTATUS_MIE];
  assign trap_taken  = inst_ecall_i | inst_ebreak_i | irq_taken;
  assign event_taken = (state_q == IDLE) & ~sys_reset & (trap_taken | inst_mret_i);
  assign mtvec_base  = csr_mtvec_i & 32'hFFFF_FFFC;

`ifdef CLINT_VECTORED_EN
  assign trap_target = (csr_mtvec_i[1:0] == 2'b01 && cause_q[31])
                       ? mtvec_base + {cause_q[29:0], 2'b00} : mtvec_base;
`else
  assign trap_target = mtvec_base;
`endif

  always_comb begin
    mstatus_trap                                  = csr_mstatus_i;
    mstatus_trap[MSTATUS_MPIE]                    = csr_mstatus_i[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]                     = 1'b0;
    mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = PRIVILEG_MACHINE;
    mstatus_mret                                  = csr_mstatus_i;
    mstatus_mret[MSTATUS_MIE]                     = csr_mstatus_i[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE]                    = 1'b1;
    mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = PRIVILEG_USER;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      is_mret_q <= is_mret_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cause_d             = cause_q;
    epc_d               = epc_q;
    is_mret_d           = is_mret_q;
    clint_wr_en_o       = 1'b0;
    clint_wr_addr_o     = 32'd0;
    clint_wr_data_o     = 32'd0;
    wr_privilege_en_o   = 1'b0;
    wr_privilege_ctrl_o = 2'b00;
    int_assert_o        = 1'b0;
    int_addr_o          = RESET_ADDR;
    hold_o              = (state_q != IDLE) | event_taken;

    unique case (state_q)
      IDLE: begin
        // Priority: ecall > ebreak > mret > timer irq
        if (trap_taken && !(inst_mret_i && !inst_ecall_i && !inst_ebreak_i)) begin
          state_d   = W_MEPC;
          epc_d     = inst_addr_i;
          is_mret_d = 1'b0;
          cause_d   = inst_ecall_i  ? CAUSE_ECALL  :
                      inst_ebreak_i ? CAUSE_EBREAK : CAUSE_MTIMER;
        end else if (inst_mret_i) begin
          state_d   = W_MSTATUS_MRET;
          is_mret_d = 1'b1;
        end
      end
      W_MEPC: begin
        clint_wr_en_o   = 1'b1;
        clint_wr_addr_o = csr_addr(CSR_MEPC);
        clint_wr_data_o = epc_q;
        state_d         = W_MSTATUS;
      end
      W_MSTATUS: begin
        clint_wr_en_o       = 1'b1;
        clint_wr_addr_o     = csr_addr(CSR_MSTATUS);
        clint_wr_data_o     = mstatus_trap;
        wr_privilege_en_o   = 1'b1;
        wr_privilege_ctrl_o = PRIVILEG_MACHINE;
        state_d             = W_MCAUSE;
      end
      W_MCAUSE: begin
        clint_wr_en_o   = 1'b1;
        clint_wr_addr_o = csr_addr(CSR_MCAUSE);
        clint_wr_data_o = cause_q;
        state_d         = ASSERT;
      end
      W_MSTATUS_MRET: begin
        clint_wr_en_o       = 1'b1;
        clint_wr_addr_o     = csr_addr(CSR_MSTATUS);
        clint_wr_data_o     = mstatus_mret;
        wr_privilege_en_o   = 1'b1;
        wr_privilege_ctrl_o = csr_mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        state_d             = ASSERT;
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = is_mret_q ? csr_mepc_i : trap_target;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
